// File: rtl/apb2apb_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : apb2apb_bridge_if
// Description : Request/response bundle between a client and apb2apb_bridge.
//               master modport = client side (issues requests)
//               slave  modport = bridge side (serves requests)
// Signals     : trnsfr, wr, dsel[1:0], address, data_in  (client -> bridge)
//               data_out, ready, slverr                  (bridge -> client)
// Revision    : 1.0 - initial release
// ============================================================================
interface apb2apb_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  trnsfr;
    logic                  wr;
    logic [1:0]            dsel;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ready;
    logic                  slverr;

    modport master (
        output trnsfr, wr, dsel, address, data_in,
        input  data_out, ready, slverr
    );

    modport slave (
        input  trnsfr, wr, dsel, address, data_in,
        output data_out, ready, slverr
    );
endinterface
`default_nettype wire

// File: rtl/apb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb2apb_bridge
// Description : APB master FSM (IDLE/SETUP/ACCESS) wired to an internal APB
//               slave memory with one wait state. Every transfer takes three
//               cycles; ready pulses in the completion cycle. Out-of-range
//               addresses and reserved size select raise slverr.
// Ports       : clk      - clock, rising edge
//               rst_n    - asynchronous active-low reset
//               bus      - apb2apb_bridge_if.slave request/response bundle
// Revision    : 1.0 - initial release
// ============================================================================
module apb2apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    apb2apb_bridge_if.slave   bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // ---------------- master side ----------------
    state_t                r_state;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;
    logic                  r_strb_err;   // reserved dsel travels with the request

    // ---------------- slave side ----------------
    logic                  r_pready;
    logic                  r_pslverr;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [STRB_W-1:0]     w_strb;
    logic                  w_strb_err;
    logic                  w_start;
    logic                  w_access;
    logic                  w_complete;
    logic                  w_err;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_rd_masked;

    // Size select to byte-lane strobe; reserved code flags an error.
    always_comb begin
        w_strb     = '0;
        w_strb_err = 1'b0;
        case (bus.dsel)
            2'd0:    w_strb = '1;
            2'd1:    w_strb = STRB_W'(2'b11);
            2'd2:    w_strb = STRB_W'(1'b1);
            default: w_strb_err = 1'b1;
        endcase
    end

    // A new request is accepted from IDLE or on the completion edge of ACCESS;
    // anything seen on trnsfr in between is ignored.
    assign w_access   = r_psel && r_penable;
    assign w_complete = w_access && r_pready;
    assign w_start    = bus.trnsfr && ((r_state == S_IDLE) ||
                                       ((r_state == S_ACCESS) && r_pready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_pstrb    <= '0;
            r_strb_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.trnsfr) begin
                        r_state   <= S_SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (r_pready) begin
                        if (bus.trnsfr) begin
                            r_state   <= S_SETUP;
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                        end else begin
                            r_state   <= S_IDLE;
                            r_psel    <= 1'b0;
                            r_penable <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
            if (w_start) begin
                r_pwrite   <= bus.wr;
                r_paddr    <= bus.address;
                r_pwdata   <= bus.data_in;
                r_pstrb    <= w_strb;
                r_strb_err <= w_strb_err;
            end
        end
    end

    // Full address compared, so nothing above MEM_DEPTH aliases into memory.
    assign w_err     = r_strb_err || ({1'b0, r_paddr} >= c_depth);
    assign w_idx     = r_paddr[IDX_W-1:0];
    assign w_rd_word = r_mem[w_idx];

    for (genvar b = 0; b < STRB_W; b++) begin : g_rd_lane
        assign w_rd_masked[b*8 +: 8] = r_pstrb[b] ? w_rd_word[b*8 +: 8] : 8'h00;
    end

    // One wait state: pready rises in the second ACCESS cycle only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_data_out <= '0;
        end else begin
            if (w_access && !r_pready) begin
                r_pready  <= 1'b1;
                r_pslverr <= w_err;
            end else begin
                r_pready  <= 1'b0;
                r_pslverr <= 1'b0;
            end
            if (w_complete && !r_pwrite) begin
                r_data_out <= w_err ? '0 : w_rd_masked;
            end
        end
    end

    // Memory has no reset; an async reset clears psel, which blocks the write.
    always_ff @(posedge clk) begin
        if (w_complete && r_pwrite && !w_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (r_pstrb[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= r_pwdata[b*8 +: 8];
                end
            end
        end
    end

    assign bus.ready    = r_pready;
    assign bus.slverr   = r_pslverr;
    assign bus.data_out = r_data_out;
endmodule
`default_nettype wire

// File: tb/tb_apb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb2apb_bridge
// Description : Directed bench for apb2apb_bridge. A transaction-level model
//               (word array + pending request with its sample cycle) predicts
//               ready/slverr/data_out every cycle; directed transfers also
//               carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb2apb_bridge;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   n_rdy;

    apb2apb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb2apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] m_mem [256];
    logic [31:0] m_dout;
    int          cyc;
    bit          busy;
    int          t_n;
    bit          t_wr;
    logic [1:0]  t_ds;
    logic [31:0] t_a;
    logic [31:0] t_d;

    function automatic logic [31:0] lane_mask(input logic [1:0] ds);
        case (ds)
            2'd0:    return 32'hFFFF_FFFF;
            2'd1:    return 32'h0000_FFFF;
            2'd2:    return 32'h0000_00FF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_err(input logic [31:0] a, input logic [1:0] ds);
        return (a >= 32'd256) || (ds == 2'd3);
    endfunction

    initial begin
        m_dout = '0;
        cyc    = 0;
        busy   = 0;
        t_n    = 0;
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            busy   = 0;
            m_dout = '0;
        end else begin
            if (busy && cyc == t_n + 3) begin
                if (is_err(t_a, t_ds)) begin
                    if (!t_wr) m_dout = '0;
                end else if (t_wr) begin
                    m_mem[t_a[7:0]] = (m_mem[t_a[7:0]] & ~lane_mask(t_ds)) | (t_d & lane_mask(t_ds));
                end else begin
                    m_dout = m_mem[t_a[7:0]] & lane_mask(t_ds);
                end
                busy = 0;
            end
            if (!busy && bus.trnsfr) begin
                t_wr = bus.wr;
                t_ds = bus.dsel;
                t_a  = bus.address;
                t_d  = bus.data_in;
                t_n  = cyc;
                busy = 1;
            end
        end
    end

    // Compare process: outputs are settled mid-cycle.
    always @(negedge clk) begin
        bit exp_rdy;
        exp_rdy = rst_n && busy && (cyc == t_n + 2);
        if (bus.ready) n_rdy++;
        check("ready", {31'b0, bus.ready}, {31'b0, exp_rdy});
        if (exp_rdy)
            check("slverr", {31'b0, bus.slverr}, {31'b0, is_err(t_a, t_ds)});
        else if (!rst_n)
            check("slverr_rst", {31'b0, bus.slverr}, 32'h0);
        check("data_out", bus.data_out, rst_n ? m_dout : 32'h0);
    end

    // ---------------- stimulus ----------------
    // Entered 2 time units after a rising edge with the bridge idle.
    task automatic txn(input bit w, input logic [1:0] ds, input logic [31:0] a,
                       input logic [31:0] d, input bit exp_err, input logic [31:0] exp_dout);
        bus.trnsfr  = 1'b1;
        bus.wr      = w;
        bus.dsel    = ds;
        bus.address = a;
        bus.data_in = d;
        @(posedge clk); #2;
        bus.trnsfr = 1'b0;
        check("lat_e0_ready", {31'b0, bus.ready}, 32'h0);
        @(posedge clk); #2;
        check("lat_e1_ready", {31'b0, bus.ready}, 32'h0);
        @(posedge clk); #2;
        check("lat_e2_ready", {31'b0, bus.ready}, 32'h1);
        check("lat_e2_slverr", {31'b0, bus.slverr}, {31'b0, exp_err});
        @(posedge clk); #2;
        check("lat_e3_ready", {31'b0, bus.ready}, 32'h0);
        check("txn_data_out", bus.data_out, exp_dout);
    endtask

    task automatic burst(input bit w);
        bus.trnsfr  = 1'b1;
        bus.wr      = w;
        bus.dsel    = 2'd0;
        bus.address = 32'hB0;
        bus.data_in = 32'hC0D9_42F0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            repeat (2) @(posedge clk);
            #2;
            if (i < 7) begin
                bus.address = 32'hB0 + 32'(i + 1);
                bus.data_in = 32'hC0D9_42F0 + 32'(i + 1);
            end else begin
                bus.trnsfr = 1'b0;
            end
        end
        @(posedge clk); #2;
    endtask

    initial begin
        int n0;
        total       = 0;
        bad         = 0;
        n_rdy       = 0;
        rst_n       = 1'b0;
        bus.trnsfr  = 1'b0;
        bus.wr      = 1'b0;
        bus.dsel    = 2'd0;
        bus.address = '0;
        bus.data_in = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", {31'b0, bus.ready}, 32'h0);
        check("rst_data_out", bus.data_out, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        txn(1, 2'd0, 32'hF0, 32'h000A_3210, 0, 32'h0);
        txn(0, 2'd0, 32'hF0, 32'h0,         0, 32'h000A_3210);
        txn(0, 2'd2, 32'hF0, 32'h0,         0, 32'h0000_0010);
        txn(1, 2'd1, 32'h12, 32'h510F_CB29, 0, 32'h0000_0010);
        txn(0, 2'd1, 32'h12, 32'h0,         0, 32'h0000_CB29);
        txn(1, 2'd0, 32'h3D, 32'hFFFF_FFFF, 0, 32'h0000_CB29);
        txn(1, 2'd2, 32'h3D, 32'h0102_1034, 0, 32'h0000_CB29);
        txn(0, 2'd0, 32'h3D, 32'h0,         0, 32'hFFFF_FF34);

        // Out-of-range write must not alias onto word 0.
        txn(1, 2'd0, 32'h00,  32'hA5A5_A5A5, 0, 32'hFFFF_FF34);
        txn(1, 2'd0, 32'h100, 32'h0102_1034, 1, 32'hFFFF_FF34);
        txn(0, 2'd0, 32'h00,  32'h0,         0, 32'hA5A5_A5A5);
        txn(0, 2'd1, 32'h200, 32'h0,         1, 32'h0);
        txn(1, 2'd3, 32'h12,  32'hFFFF_FFFF, 1, 32'h0);
        txn(0, 2'd1, 32'h12,  32'h0,         0, 32'h0000_CB29);
        txn(0, 2'd3, 32'h12,  32'h0,         1, 32'h0);
        txn(0, 2'd0, 32'h400, 32'h0,         1, 32'h0);

        n0 = n_rdy;
        burst(1);
        check("burst_wr_pulses", 32'(n_rdy - n0), 32'd8);
        n0 = n_rdy;
        burst(0);
        check("burst_rd_pulses", 32'(n_rdy - n0), 32'd8);
        check("burst_rd_last", bus.data_out, 32'hC0D9_42F7);
        txn(0, 2'd0, 32'hB3, 32'h0, 0, 32'hC0D9_42F3);

        // Reset during the ACCESS wait cycle aborts the write.
        txn(1, 2'd0, 32'h20, 32'h1122_3344, 0, 32'hC0D9_42F3);
        bus.trnsfr  = 1'b1;
        bus.wr      = 1'b1;
        bus.dsel    = 2'd0;
        bus.address = 32'h20;
        bus.data_in = 32'hDEAD_BEEF;
        @(posedge clk); #2;
        bus.trnsfr = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'b0, bus.ready}, 32'h0);
        check("abort_data_out", bus.data_out, 32'h0);
        @(posedge clk); #2;
        check("abort_no_pulse", {31'b0, bus.ready}, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        txn(0, 2'd0, 32'h20, 32'h0, 0, 32'h1122_3344);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
